// File: rtl/edf_sched_pkg.sv
// Shared types and helpers for the EDF receive scheduler.
// Deadlines are compared modulo 2^TIME_W, so every comparison goes through dl_before().
package edf_sched_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int CLS_HI = 13;
    localparam int CLS_LO = 12;
    localparam int DESC_W = 16;
    localparam int PORT_W = 3;

    // a is earlier than b when (a - b), read as a signed w-bit value, is negative.
    // The difference is shifted up so that bit w-1 lands in bit 31.
    function automatic logic dl_before(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [31:0] d;
        d = (a - b) << (32 - w);
        return d[31];
    endfunction

endpackage

// File: rtl/edf_min_sel.sv
// Combinational earliest-deadline selector built as a binary tree.
// The left child wins unless the right one is strictly earlier, so the lowest index wins ties.
module edf_min_sel
    import edf_sched_pkg::*;
#(
    parameter int NPORT  = 4,
    parameter int TIME_W = 16
) (
    input  logic [NPORT-1:0]             vld_i,
    input  logic [NPORT-1:0][TIME_W-1:0] dl_i,
    output logic [PORT_W-1:0]            idx_o,
    output logic                         vld_o
);

    localparam int LVL = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int N2  = 1 << LVL;

    // Heap layout: node 1 is the root, leaves occupy N2..2*N2-1.
    logic              nv [1:2*N2-1];
    logic [TIME_W-1:0] nd [1:2*N2-1];
    logic [PORT_W-1:0] ni [1:2*N2-1];

    genvar i;
    for (i = 0; i < N2; i++) begin : g_leaf
        if (i < NPORT) begin : g_real
            assign nv[N2+i] = vld_i[i];
            assign nd[N2+i] = dl_i[i];
            assign ni[N2+i] = PORT_W'(i);
        end else begin : g_pad
            assign nv[N2+i] = 1'b0;
            assign nd[N2+i] = '0;
            assign ni[N2+i] = '0;
        end
    end

    for (i = 1; i < N2; i++) begin : g_node
        logic take_r;
        assign take_r = nv[2*i+1] &&
                        (!nv[2*i] || dl_before(32'(nd[2*i+1]), 32'(nd[2*i]), TIME_W));
        assign nv[i] = nv[2*i] | nv[2*i+1];
        assign nd[i] = take_r ? nd[2*i+1] : nd[2*i];
        assign ni[i] = take_r ? ni[2*i+1] : ni[2*i];
    end

    assign idx_o = ni[1];
    assign vld_o = nv[1];

endmodule

// File: rtl/edf_rx_sched.sv
// Earliest-deadline-first drain of NPORT MAC receive FIFO pairs into one byte stream.
// Each port keeps one prefetched descriptor stamped with an absolute deadline.
module edf_rx_sched
    import edf_sched_pkg::*;
#(
    parameter int NPORT  = 4,
    parameter int LEN_W  = 12,
    parameter int TIME_W = 16,
    parameter int SLACK0 = 64,
    parameter int SLACK1 = 250,
    parameter int SLACK2 = 1000,
    parameter int SLACK3 = 4000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NPORT-1:0]      ptr_fifo_empty,
    output logic [NPORT-1:0]      ptr_fifo_rd,
    input  logic [16*NPORT-1:0]   ptr_fifo_dout,
    output logic [NPORT-1:0]      data_fifo_rd,
    input  logic [8*NPORT-1:0]    data_fifo_dout,
    input  logic [LEN_W:0]        out_free,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [2:0]            out_port,
    output logic                  busy,
    output logic [15:0]           miss_cnt
);

    state_e                        state_q, state_d;
    logic [TIME_W-1:0]             now_q;
    logic [NPORT-1:0]              head_v_q, pend_q;
    logic [NPORT-1:0][LEN_W-1:0]   len_q;
    logic [NPORT-1:0][TIME_W-1:0]  dl_q;
    logic [PORT_W-1:0]             g_q;
    logic [LEN_W-1:0]              cnt_q;
    logic                          first_q, vld_q, sop_q, eop_q;
    logic [15:0]                   miss_q;

    logic [PORT_W-1:0]             win_idx;
    logic                          win_v;
    logic [LEN_W-1:0]              win_len;
    logic [TIME_W-1:0]             win_dl;
    logic                          arb_drop, grant, win_late;
    logic                          unused_desc;

    function automatic logic [TIME_W-1:0] slack_of(input logic [1:0] cls);
        case (cls)
            2'd0:    return TIME_W'(SLACK0);
            2'd1:    return TIME_W'(SLACK1);
            2'd2:    return TIME_W'(SLACK2);
            default: return TIME_W'(SLACK3);
        endcase
    endfunction

    edf_min_sel #(.NPORT(NPORT), .TIME_W(TIME_W)) u_min_sel (
        .vld_i (head_v_q),
        .dl_i  (dl_q),
        .idx_o (win_idx),
        .vld_o (win_v)
    );

    always_comb begin
        win_len = '0;
        win_dl  = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (win_idx == PORT_W'(p)) begin
                win_len = len_q[p];
                win_dl  = dl_q[p];
            end
        end
    end

    // A stalled winner blocks arbitration: no other port is tried in its place.
    assign arb_drop = (state_q == ST_ARB) && win_v && (win_len == '0);
    assign grant    = (state_q == ST_ARB) && win_v && (win_len != '0) &&
                      (out_free >= {1'b0, win_len});
    assign win_late = dl_before(32'(win_dl), 32'(now_q), TIME_W);

    // One pop in flight per port: pend_q blocks a second pop until the head is captured.
    assign ptr_fifo_rd = rstn ? (~head_v_q & ~pend_q & ~ptr_fifo_empty) : '0;
    assign unused_desc = ^ptr_fifo_dout;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            now_q    <= '0;
            head_v_q <= '0;
            pend_q   <= '0;
            len_q    <= '0;
            dl_q     <= '0;
            g_q      <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            vld_q    <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            miss_q   <= '0;
        end else begin
            now_q  <= now_q + TIME_W'(1);
            pend_q <= ptr_fifo_rd;
            for (int p = 0; p < NPORT; p++) begin
                if (pend_q[p]) begin
                    len_q[p]    <= ptr_fifo_dout[DESC_W*p +: LEN_W];
                    dl_q[p]     <= now_q + slack_of(ptr_fifo_dout[DESC_W*p+CLS_LO +: 2]);
                    head_v_q[p] <= 1'b1;
                end else if ((arb_drop || grant) && win_idx == PORT_W'(p)) begin
                    head_v_q[p] <= 1'b0;
                end
            end
            if (grant) begin
                g_q     <= win_idx;
                cnt_q   <= win_len;
                first_q <= 1'b1;
                if (win_late && miss_q != 16'hFFFF)
                    miss_q <= miss_q + 16'd1;
            end else if (state_q == ST_XFER) begin
                cnt_q   <= cnt_q - LEN_W'(1);
                first_q <= 1'b0;
            end
            vld_q <= (state_q == ST_XFER);
            sop_q <= (state_q == ST_XFER) && first_q;
            eop_q <= (state_q == ST_XFER) && (cnt_q == LEN_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= ST_ARB;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (grant) state_d = ST_XFER;
            ST_XFER:  if (cnt_q == LEN_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    always_comb begin
        data_fifo_rd = '0;
        for (int p = 0; p < NPORT; p++)
            data_fifo_rd[p] = (state_q == ST_XFER) && (g_q == PORT_W'(p));
        busy = (state_q != ST_ARB);
    end

    always_comb begin
        out_data = '0;
        for (int p = 0; p < NPORT; p++)
            if (g_q == PORT_W'(p)) out_data = data_fifo_dout[8*p +: 8];
    end

    assign out_valid = vld_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_port  = g_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_edf_rx_sched.sv
// Randomised bench for edf_rx_sched: FIFO models feed the DUT, an event-driven EDF model
// predicts each frame's port, first-byte cycle, length, byte signature and the late count.
module tb_edf_rx_sched;

    localparam int NP  = 4;
    localparam int INF = 32'h7fffffff;

    typedef struct { int cls; int len; } dsc_t;
    typedef struct { int port; int t; int len; int sig; } frm_t;

    logic                 clk = 1'b0, rstn = 1'b0;
    logic [NP-1:0]        ptr_fifo_empty, ptr_fifo_rd, data_fifo_rd;
    logic [NP-1:0][15:0]  pd = '0;
    logic [NP-1:0][7:0]   dd = '0;
    logic [12:0]          out_free = '0;
    logic                 out_valid, out_sop, out_eop, busy;
    logic [7:0]           out_data;
    logic [2:0]           out_port;
    logic [15:0]          miss_cnt;

    dsc_t        bd[NP][$];
    int          bl[NP];
    logic [15:0] pq[NP][$];
    logic [7:0]  dq[NP][$];
    logic [7:0]  mq[NP][$];
    bit          en[NP];
    int          pushed[NP], popped[NP];
    int          sl[4] = '{64, 250, 1000, 4000};
    int          ut = 0;
    int          n_tests = 0, n_fail = 0, miss_exp = 0;
    int          err_oh = 0, err_pe = 0, err_dpop = 0, err_proto = 0;
    frm_t        exp_q[$], got_q[$];
    int          model_end;
    int          av[NP], mdl[NP], qi[NP];

    edf_rx_sched dut (
        .clk(clk), .rstn(rstn),
        .ptr_fifo_empty(ptr_fifo_empty), .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_dout(pd),
        .data_fifo_rd(data_fifo_rd), .data_fifo_dout(dd), .out_free(out_free),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_port(out_port), .busy(busy), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    always_comb
        for (int p = 0; p < NP; p++)
            ptr_fifo_empty[p] = !(en[p] && pushed[p] != popped[p]);

    // FIFO models, one-cycle read latency; ut mirrors the time counter, unwrapped.
    initial forever begin
        @(posedge clk);
        ut <= rstn ? ut + 1 : 0;
        if (rstn && !$onehot0(data_fifo_rd)) err_oh++;
        for (int p = 0; p < NP; p++) begin
            if (ptr_fifo_rd[p]) begin
                if (ptr_fifo_empty[p]) err_pe++;
                else begin
                    pd[p]     <= pq[p].pop_front();
                    popped[p] <= popped[p] + 1;
                end
            end
            if (data_fifo_rd[p]) begin
                if (dq[p].size() == 0) err_dpop++;
                else dd[p] <= dq[p].pop_front();
            end
        end
    end

    initial begin : mon
        bit   in_fr;
        frm_t cf;
        in_fr = 0;
        cf = '{0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (!rstn) in_fr = 0;
            else if (out_valid) begin
                if (out_sop) begin
                    if (in_fr) err_proto++;
                    in_fr = 1;
                    cf = '{int'(out_port), ut, 0, 0};
                end else if (!in_fr) err_proto++;
                cf.len++;
                cf.sig = cf.sig * 31 + int'(out_data);
                if (out_eop) begin
                    got_q.push_back(cf);
                    in_fr = 0;
                end
            end else if (out_sop || out_eop) err_proto++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit earlier(input int a, input int b);
        logic [15:0] d;
        d = 16'(a - b);
        return $signed(d) < 0;
    endfunction

    task automatic refill(input int p, input int c);
        if (qi[p] < bd[p].size()) begin
            mdl[p] = (c + 2 + sl[bd[p][qi[p]].cls]) & 16'hffff;
            av[p]  = c + 3;
            qi[p]++;
        end else av[p] = INF;
    endtask

    // Event-driven EDF: jump between arrivals, grants and the out_free release point.
    task automatic model_batch(input int u0, input int R, input int lo, input int hi);
        int t, best, nxt, len, free, sig;
        t = u0;
        for (int p = 0; p < NP; p++) begin
            qi[p] = 0;
            av[p] = INF;
            if (bd[p].size() > 0) begin
                mdl[p] = (u0 + bl[p] + 1 + sl[bd[p][0].cls]) & 16'hffff;
                av[p]  = u0 + bl[p] + 2;
                qi[p]  = 1;
            end
        end
        for (int guard = 0; guard < 10000; guard++) begin
            nxt = INF;
            for (int p = 0; p < NP; p++) if (av[p] < nxt) nxt = av[p];
            if (nxt == INF) break;
            best = -1;
            for (int p = 0; p < NP; p++)
                if (av[p] <= t && (best < 0 || earlier(mdl[p], mdl[best]))) best = p;
            if (best < 0) begin t = nxt; continue; end
            len = bd[best][qi[best]-1].len;
            if (len == 0) begin refill(best, t); t++; continue; end
            free = (t < R) ? lo : hi;
            if (free < len) begin
                nxt = (t < R) ? R : INF;
                for (int p = 0; p < NP; p++) if (av[p] > t && av[p] < nxt) nxt = av[p];
                if (nxt == INF) break;
                t = nxt;
                continue;
            end
            if (earlier(mdl[best], t)) miss_exp++;
            sig = 0;
            for (int i = 0; i < len; i++) sig = sig * 31 + int'(mq[best].pop_front());
            exp_q.push_back('{best, t + 2, len, sig});
            refill(best, t);
            t += len + 2;
        end
        model_end = t;
    endtask

    // Called at a negedge; that negedge's cycle is batch-relative cycle 0.
    task automatic run_batch(input int rel, input int lo, input int hi);
        int u0, k, done_k, left;
        logic [7:0] b;
        u0 = ut;
        got_q.delete();
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            en[p] = 0;
            foreach (bd[p][i]) begin
                pq[p].push_back({2'b00, 2'(bd[p][i].cls), 12'(bd[p][i].len)});
                pushed[p]++;
                for (int j = 0; j < bd[p][i].len; j++) begin
                    b = 8'($urandom);
                    dq[p].push_back(b);
                    mq[p].push_back(b);
                end
            end
        end
        model_batch(u0, u0 + rel, lo, hi);
        k = 0;
        done_k = -1;
        while (k < 6000) begin
            for (int p = 0; p < NP; p++) en[p] = (k >= bl[p]);
            out_free = 13'((k >= rel) ? hi : lo);
            if (done_k < 0 && got_q.size() >= exp_q.size() && u0 + k >= model_end + 4) done_k = k;
            if (done_k >= 0 && k >= done_k + 20) break;
            @(negedge clk);
            k++;
        end
        chk("batch_in_time", 32'(k < 6000), 1);
        chk("frame_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("frame_port", got_q[i].port, exp_q[i].port);
            chk("frame_sop_cycle", got_q[i].t, exp_q[i].t);
            chk("frame_len", got_q[i].len, exp_q[i].len);
            chk("frame_bytes", got_q[i].sig, exp_q[i].sig);
        end
        chk("miss_cnt", miss_cnt, miss_exp & 16'hffff);
        left = 0;
        for (int p = 0; p < NP; p++) left += dq[p].size() + pq[p].size();
        chk("fifos_drained", left, 0);
        chk("protocol_errs", err_oh + err_pe + err_dpop + err_proto, 0);
        for (int p = 0; p < NP; p++) begin
            bd[p].delete();
            mq[p].delete();
            bl[p] = 0;
        end
    endtask

    task automatic rand_batch();
        dsc_t d;
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                d.cls = int'($urandom_range(0, 3));
                d.len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
                bd[p].push_back(d);
            end
            bl[p] = int'($urandom_range(0, 30));
        end
        run_batch(int'($urandom_range(0, 80)), int'($urandom_range(0, 30)), 4096);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ptr_rd"}, 32'(ptr_fifo_rd), 0);
        chk({pfx, "_data_rd"}, 32'(data_fifo_rd), 0);
        chk({pfx, "_valid"}, 32'(out_valid), 0);
        chk({pfx, "_sop"}, 32'(out_sop), 0);
        chk({pfx, "_eop"}, 32'(out_eop), 0);
        chk({pfx, "_port"}, 32'(out_port), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_miss"}, 32'(miss_cnt), 0);
    endtask

    task automatic flush_fifos();
        for (int p = 0; p < NP; p++) begin
            en[p] = 0;
            pq[p].delete();
            dq[p].delete();
            mq[p].delete();
            pushed[p] = popped[p];
        end
    endtask

    initial begin : main
        int k;
        for (int p = 0; p < NP; p++) begin en[p] = 0; pushed[p] = 0; popped[p] = 0; bl[p] = 0; end
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        bd[0].push_back('{0, 4});                                run_batch(0, 100, 100);
        bd[1].push_back('{3, 5}); bd[3].push_back('{0, 6});      run_batch(0, 4096, 4096);
        bd[0].push_back('{1, 3}); bd[2].push_back('{1, 4});      run_batch(0, 4096, 4096);
        bd[2].push_back('{0, 200});                              run_batch(40, 100, 200);
        bd[3].push_back('{0, 2});                                run_batch(150, 0, 4096);
        bd[1].push_back('{2, 0}); bd[1].push_back('{0, 3});
        bd[0].push_back('{3, 0});                                run_batch(0, 4096, 4096);
        repeat (8) rand_batch();

        // Reset in the middle of a long frame.
        pq[0].push_back({4'h0, 12'd20});
        pushed[0]++;
        for (int j = 0; j < 20; j++) dq[0].push_back(8'($urandom));
        en[0] = 1;
        out_free = 13'd4096;
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clk); k++; end
        chk("xfer_started", 32'(out_valid), 1);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midxfer_reset");
        flush_fifos();
        miss_exp = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        repeat (2) rand_batch();

        // Deadlines on both sides of the time-counter wrap.
        k = 0;
        while (ut != 32'hFF00 && k < 70000) begin @(negedge clk); k++; end
        chk("reached_wrap_point", ut, 32'hFF00);
        bd[1].push_back('{1, 5}); bl[1] = 21;
        bd[0].push_back('{0, 5}); bl[0] = 175;
        run_batch(200, 0, 4096);
        rand_batch();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
